// File: rtl/bus_arb_pkg.sv
// Shared types and requester indices for the system-bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANTED,
    OWNED
  } arb_state_t;

  localparam int REQ_VA_PA      = 0;
  localparam int REQ_ADDR_DATA  = 1;
  localparam int REQ_STORE_DATA = 2;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after last_owner+1, with wrap.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int OWNER_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [OWNER_W-1:0] last_owner_i,
  output logic [OWNER_W-1:0] pick_o,
  output logic               pick_valid_o
);

  function automatic logic [OWNER_W-1:0] wrap_idx(input int v);
    return OWNER_W'(v % NUM_REQ);
  endfunction

  always_comb begin
    pick_o       = '0;
    pick_valid_o = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!pick_valid_o && req_i[wrap_idx(int'(last_owner_i) + i)]) begin
        pick_o       = wrap_idx(int'(last_owner_i) + i);
        pick_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared system bus; grant is held for the whole busy
// transaction and revoked if the granted master never raises busy.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ       = 3,
  parameter int GRANT_TIMEOUT = 16,
  parameter int OWNER_W       = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] in_reqcyc,
  input  logic               in_bus_busy,
  output logic [NUM_REQ-1:0] out_grant,
  output logic [OWNER_W-1:0] out_owner,
  output logic               out_owner_valid,
  output logic               out_timeout
);

  localparam int CNT_W = $clog2(GRANT_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRANT_TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  arb_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [OWNER_W-1:0]  owner_q, owner_d;
  logic [OWNER_W-1:0]  last_owner_q, last_owner_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                timeout_q, timeout_d;
  logic [OWNER_W-1:0]  pick;
  logic                pick_valid;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .OWNER_W (OWNER_W)
  ) u_pick (
    .req_i        (in_reqcyc),
    .last_owner_i (last_owner_q),
    .pick_o       (pick),
    .pick_valid_o (pick_valid)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    wait_cnt_d   = wait_cnt_q;
    timeout_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A still-high busy belongs to a stale transaction; let it drain first.
        if (pick_valid && !in_bus_busy) begin
          grant_d      = ONE_HOT0 << pick;
          owner_d      = pick;
          last_owner_d = pick;
          wait_cnt_d   = '0;
          state_d      = GRANTED;
        end
      end
      GRANTED: begin
        if (in_bus_busy) begin
          state_d = OWNED;
        end else if (!in_reqcyc[owner_q]) begin
          grant_d = '0;
          state_d = IDLE;
        end else if (wait_cnt_q == CNT_LAST) begin
          grant_d   = '0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wait_cnt_d = sat_inc(wait_cnt_q);
        end
      end
      OWNED: begin
        if (!in_bus_busy) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= OWNER_W'(REQ_VA_PA);
      last_owner_q <= OWNER_W'(NUM_REQ - 1);
      wait_cnt_q   <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      wait_cnt_q   <= wait_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign out_grant       = grant_q;
  assign out_owner       = owner_q;
  assign out_owner_valid = |grant_q;
  assign out_timeout     = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model.
module tb_bus_arbiter;

  localparam int N = 3;
  localparam int T = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] req = '0;
  logic         busy = 1'b0;
  logic [N-1:0] out_grant;
  logic [1:0]   out_owner;
  logic         out_owner_valid;
  logic         out_timeout;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who holds the bus (-1 none), whether busy was seen,
  // how many cycles the current grant has been visible, and whose turn was last.
  int m_cur   = -1;
  int m_last  = N - 1;
  int m_owner = 0;
  int m_age   = 0;
  bit m_seen  = 0;
  bit m_to    = 0;

  bus_arbiter #(.NUM_REQ(N), .GRANT_TIMEOUT(T)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_reqcyc       (req),
    .in_bus_busy     (busy),
    .out_grant       (out_grant),
    .out_owner       (out_owner),
    .out_owner_valid (out_owner_valid),
    .out_timeout     (out_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_cur >= 0) g[m_cur] = 1'b1;
    return g;
  endfunction

  task automatic model_step();
    m_to = 0;
    if (!reset) begin
      m_cur = -1; m_last = N - 1; m_owner = 0; m_age = 0; m_seen = 0;
    end else if (m_cur < 0) begin
      if (req != '0 && !busy) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (m_cur < 0 && req[c]) m_cur = c;
        end
        m_last = m_cur; m_owner = m_cur; m_age = 1; m_seen = 0;
      end
    end else if (!m_seen) begin
      if (busy) m_seen = 1;
      else if (!req[m_cur]) m_cur = -1;
      else if (m_age == T) begin m_cur = -1; m_to = 1; end
      else m_age++;
    end else if (!busy) begin
      m_cur = -1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; req = '0; busy = 1'b0;
    step(); step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (out_grant !== 3'b000) begin n_err++; $display("FAIL reset_grant got=%b exp=000", out_grant); end
    n_cmp++; if (out_owner_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", out_owner_valid); end
    n_cmp++; if (out_timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout got=%b exp=0", out_timeout); end
    n_cmp++; if (out_owner !== 2'd0) begin n_err++; $display("FAIL reset_owner got=%0d exp=0", out_owner); end
  endtask

  task automatic test_single_grant();
    do_reset();
    req = 3'b010;
    step();
    n_cmp++; if (out_grant !== 3'b010) begin n_err++; $display("FAIL single_grant got=%b exp=010", out_grant); end
    n_cmp++; if (out_owner !== 2'd1 || out_owner_valid !== 1'b1) begin n_err++; $display("FAIL single_owner got=%0d/%b exp=1/1", out_owner, out_owner_valid); end
    busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (out_grant !== 3'b010 || out_timeout !== 1'b0) begin n_err++; $display("FAIL single_hold cyc=%0d got=%b/%b exp=010/0", i, out_grant, out_timeout); end
    end
    busy = 1'b0;
    step();
    n_cmp++; if (out_grant !== 3'b000 || out_timeout !== 1'b0) begin n_err++; $display("FAIL single_release got=%b/%b exp=000/0", out_grant, out_timeout); end
    req = '0;
    step();
  endtask

  task automatic test_rr_order();
    logic [N-1:0] order [4];
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
    do_reset();
    req = 3'b111;
    step();
    for (int g = 0; g < 4; g++) begin
      n_cmp++; if (out_grant !== order[g]) begin n_err++; $display("FAIL rr_order idx=%0d got=%b exp=%b", g, out_grant, order[g]); end
      busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
        step();
        n_cmp++; if (!$onehot0(out_grant) || out_grant !== exp_grant()) begin n_err++; $display("FAIL rr_hold idx=%0d got=%b exp=%b", g, out_grant, exp_grant()); end
      end
      busy = 1'b0;
      step();
      n_cmp++; if (out_grant !== 3'b000) begin n_err++; $display("FAIL rr_idle_gap idx=%0d got=%b exp=000", g, out_grant); end
      step();
    end
    req = '0;
    step(); step();
  endtask

  task automatic test_timeout();
    int high_cnt;
    int pulses;
    do_reset();
    req = 3'b011;
    step();
    n_cmp++; if (out_grant !== 3'b001) begin n_err++; $display("FAIL to_first got=%b exp=001", out_grant); end
    high_cnt = 1;
    pulses = 0;
    for (int i = 0; i < 40 && out_grant != '0; i++) begin
      step();
      if (out_timeout) pulses++;
      if (out_grant != '0) high_cnt++;
    end
    n_cmp++; if (high_cnt !== T) begin n_err++; $display("FAIL to_length got=%0d exp=%0d", high_cnt, T); end
    n_cmp++; if (out_timeout !== 1'b1 || out_grant !== 3'b000) begin n_err++; $display("FAIL to_pulse got=%b/%b exp=1/000", out_timeout, out_grant); end
    step();
    if (out_timeout) pulses++;
    n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL to_pulse_count got=%0d exp=1", pulses); end
    n_cmp++; if (out_grant !== 3'b010 || out_owner !== 2'd1) begin n_err++; $display("FAIL to_next got=%b/%0d exp=010/1", out_grant, out_owner); end
    req = '0;
    step(); step();
  endtask

  task automatic test_withdraw();
    do_reset();
    req = 3'b100;
    step();
    n_cmp++; if (out_grant !== 3'b100) begin n_err++; $display("FAIL wd_grant got=%b exp=100", out_grant); end
    step(); step();
    req = '0;
    step();
    n_cmp++; if (out_grant !== 3'b000 || out_timeout !== 1'b0) begin n_err++; $display("FAIL wd_clear got=%b/%b exp=000/0", out_grant, out_timeout); end
    step();
    n_cmp++; if (out_grant !== 3'b000 || out_timeout !== 1'b0) begin n_err++; $display("FAIL wd_idle got=%b/%b exp=000/0", out_grant, out_timeout); end
  endtask

  task automatic test_busy_block();
    do_reset();
    busy = 1'b1;
    req = 3'b001;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (out_grant !== 3'b000) begin n_err++; $display("FAIL bb_blocked cyc=%0d got=%b exp=000", i, out_grant); end
    end
    busy = 1'b0;
    step();
    n_cmp++; if (out_grant !== 3'b001) begin n_err++; $display("FAIL bb_after got=%b exp=001", out_grant); end
    req = '0;
    step(); step();
  endtask

  task automatic test_reset_owned();
    do_reset();
    req = 3'b010;
    step();
    busy = 1'b1;
    step(); step();
    n_cmp++; if (out_grant !== 3'b010) begin n_err++; $display("FAIL ro_owned got=%b exp=010", out_grant); end
    reset = 1'b0;
    step();
    n_cmp++; if (out_grant !== 3'b000 || out_owner_valid !== 1'b0) begin n_err++; $display("FAIL ro_cleared got=%b/%b exp=000/0", out_grant, out_owner_valid); end
    reset = 1'b1;
    busy = 1'b0;
    req = 3'b111;
    step();
    n_cmp++; if (out_grant !== 3'b001 || out_owner !== 2'd0) begin n_err++; $display("FAIL ro_first got=%b/%0d exp=001/0", out_grant, out_owner); end
    req = '0;
    step(); step();
  endtask

  task automatic test_random();
    int rate;
    do_reset();
    rate = 6;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 100 == 0) begin
        case ($urandom_range(2))
          0: rate = 2;
          1: rate = 6;
          default: rate = 40;
        endcase
      end
      for (int b = 0; b < N; b++)
        if ($urandom_range(7) == 0) req[b] = ~req[b];
      if ($urandom_range(rate - 1) == 0) busy = ~busy;
      step();
      n_cmp++; if (out_grant !== exp_grant() || !$onehot0(out_grant)) begin n_err++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, out_grant, exp_grant()); end
      n_cmp++; if (out_owner_valid !== (m_cur >= 0)) begin n_err++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, out_owner_valid, (m_cur >= 0)); end
      n_cmp++; if (int'(out_owner) != m_owner) begin n_err++; $display("FAIL rnd_owner cyc=%0d got=%0d exp=%0d", cyc, out_owner, m_owner); end
      n_cmp++; if (out_timeout !== m_to) begin n_err++; $display("FAIL rnd_timeout cyc=%0d got=%b exp=%b", cyc, out_timeout, m_to); end
    end
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_rr_order();
    test_timeout();
    test_withdraw();
    test_busy_block();
    test_reset_owned();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares the single system bus port between the core's bus masters: page-walk (VA→PA), instruction/data fetch, and store write-back. It sits between the masters' request/busy lines and the shared bus interface. It issues a registered one-hot grant and holds it for the whole bus transaction, as indicated by the ORed busy line. A wait timeout reclaims grants that a master never uses.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters; index 0 = va_pa, 1 = addr_data, 2 = store_data
- GRANT_TIMEOUT, 16, cycles a grant may wait for bus_busy before it is revoked (≥2)
- OWNER_W, $clog2(NUM_REQ), width of the owner index

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low: reset==0 at a rising edge resets the block
- in_reqcyc  in  NUM_REQ  per-master request; level, held until served or withdrawn
- in_bus_busy  in  1  OR of all masters' bus-busy lines
- out_grant  out  NUM_REQ  registered one-hot grant (all-zero when idle)
- out_owner  out  OWNER_W  index of the current/last granted master
- out_owner_valid  out  1  1 when out_grant is non-zero
- out_timeout  out  1  one-cycle pulse when a grant is revoked by timeout

## Operation
- FSM states: IDLE, GRANTED (grant issued, waiting for busy), OWNED (transaction in flight).
- IDLE:
  - If any in_reqcyc bit is 1 and in_bus_busy==0, the arbiter picks the first requester at or after (last_owner+1) mod NUM_REQ, scanning upward with wrap.
  - It sets out_grant, out_owner and last_owner, clears wait_cnt, and moves to GRANTED.
  - If in_bus_busy==1 it issues no grant, because a stale transaction is still draining.
- GRANTED:
  - in_bus_busy==1 → OWNED.
  - Otherwise, if the owner's in_reqcyc==0, the master has withdrawn: clear the grant and go to IDLE.
  - Otherwise, if wait_cnt==GRANT_TIMEOUT-1: clear the grant, pulse out_timeout, go to IDLE.
  - Otherwise wait_cnt increments.
- OWNED: the grant is held while in_bus_busy==1, whatever the requests do. When in_bus_busy==0: clear the grant, go to IDLE.
- last_owner advances only when a grant is issued. Withdrawn or timed-out grants still count as that master's turn, so no master is starved.
- Requests from non-owners are ignored outside IDLE.
- wait_cnt is $clog2(GRANT_TIMEOUT) bits wide, saturates, and is cleared on entry to GRANTED.

## Timing
- Reset values:
  - out_grant=0, out_owner_valid=0, out_timeout=0, out_owner=0
  - last_owner=NUM_REQ-1, so master 0 wins the first arbitration
  - state=IDLE, wait_cnt=0
- Grant latency: a request sampled in IDLE at edge k gives out_grant high from edge k (visible cycle k+1).
- Release: in_bus_busy low sampled at edge k gives out_grant low after edge k. The FSM spends at least one IDLE cycle before the next grant, so a new grant appears after edge k+1 at the earliest.
- Throughput: at most one new grant per 2 cycles, plus the transaction length.
- Timeout: the grant is asserted for exactly GRANT_TIMEOUT cycles, then drops. out_timeout is high in the first cycle after the drop.
- Simultaneous events:
  - In GRANTED, busy rising takes priority over withdrawal and over timeout.
  - Reset takes priority over everything: reset low mid-OWNED clears the grant at that edge, even if in_bus_busy stays high.
- out_owner_valid always equals |out_grant. out_grant is never multi-hot.

## Structure
- Shared package bus_arb_pkg:
  - arb_state_t enum {IDLE, GRANTED, OWNED}
  - localparams REQ_VA_PA=0, REQ_ADDR_DATA=1, REQ_STORE_DATA=2
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req vector, last_owner.
  - Outputs: pick index, pick_valid.
  - It is reused by any future multi-port arbiter.
- The top-level bus wiring ties in_bus_busy to the OR of the three masters' busy lines. The grant vector bits map to the per-master grant inputs.

## Test plan
- Reset release, in_reqcyc=3'b010 held → out_grant=3'b010 one cycle later. Busy high 5 cycles then low → grant drops the same edge busy is sampled low. out_timeout stays 0.
- After reset, in_reqcyc=3'b111 and each master runs a 3-cycle busy → grant order 001, 010, 100, 001. There is at least one idle cycle between grants, and grant is never multi-hot.
- Grant to master 0, busy never rises, request held → grant high exactly 16 cycles, then 0, out_timeout pulses once. The next grant goes to master 1 if it is requesting.
- Grant to master 2; master 2 drops reqcyc 3 cycles later with no busy → grant clears next edge, no timeout pulse, FSM back in IDLE.
- Busy already high in IDLE with requests pending → no grant until busy falls. Grant follows 1 cycle later.
- Reset driven low in OWNED with busy high → out_grant=0, out_owner_valid=0 after that edge. After reset release, master 0 wins first.
